// File: rtl/gci_std_kmc_pkg.sv
// gci_std_kmc_pkg: shared PS/2 receiver state encoding and 50 MHz timing defaults
package gci_std_kmc_pkg;
  typedef enum logic [1:0] {L_PS2_IDLE, L_PS2_DATA, L_PS2_PARITY, L_PS2_STOP} ps2_state_t;
  localparam int L_FILTER_CYCLES_50MHZ = 1250;
  localparam int L_TIMEOUT_CYCLES_50MHZ = 100000;
endpackage

// File: rtl/gci_std_kmc_ps2_filter.sv
// gci_std_kmc_ps2_filter: two-flop synchroniser plus stability counter for one PS/2 line
module gci_std_kmc_ps2_filter #(
  parameter int P_FILTER_CYCLES = 1250
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iIN,
  output logic oOUT
);
  logic [1:0] sync_q, sync_d;
  logic out_q, out_d;
  logic [15:0] cnt_q, cnt_d;
  logic diff;
  assign diff = sync_q[1] != out_q;
  assign oOUT = out_q;
  // output follows the synchronised level only after it has differed for P_FILTER_CYCLES cycles
  always_comb begin
    sync_d = {sync_q[0], iIN};
    cnt_d = diff ? cnt_q + 16'd1 : 16'd0;
    out_d = out_q;
    if (diff && cnt_q == 16'(P_FILTER_CYCLES - 1)) begin
      out_d = sync_q[1];
      cnt_d = 16'd0;
    end
  end
  // idle PS/2 lines are high, so everything resets to 1
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      sync_q <= 2'b11;
      out_q <= 1'b1;
      cnt_q <= 16'd0;
    end else begin
      sync_q <= sync_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/gci_std_kmc_ps2_rx_frame.sv
// gci_std_kmc_ps2_rx_frame: PS/2 device-to-host frame decoder with FWFT byte FIFO
module gci_std_kmc_ps2_rx_frame
  import gci_std_kmc_pkg::*;
#(
  parameter int P_FILTER_CYCLES = L_FILTER_CYCLES_50MHZ,
  parameter int P_TIMEOUT_CYCLES = L_TIMEOUT_CYCLES_50MHZ,
  parameter int P_FIFO_AW = 2
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iCLEAR,
  input  logic               iPS2_CLOCK,
  input  logic               iPS2_DATA,
  output logic               oRX_VALID,
  output logic [7:0]         oRX_DATA,
  input  logic               iRX_READY,
  output logic [P_FIFO_AW:0] oFIFO_COUNT,
  output logic               oBUSY,
  output logic               oERR_FRAME,
  output logic               oERR_PARITY,
  output logic               oERR_TIMEOUT,
  output logic               oERR_OVERFLOW
);
  localparam int L_DEPTH = 2 ** P_FIFO_AW;
  localparam int L_TW = ($clog2(P_TIMEOUT_CYCLES) > 17) ? $clog2(P_TIMEOUT_CYCLES) : 17;
  logic fclk, fdat, fall;
  logic clk_d1_q;
  ps2_state_t state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic par_q, par_d;
  logic [L_TW-1:0] tmo_q, tmo_d;
  logic err_frame_q, err_frame_d, err_parity_q, err_parity_d;
  logic err_timeout_q, err_timeout_d, err_overflow_q, err_overflow_d;
  logic [7:0] mem_q [L_DEPTH];
  logic [7:0] mem_d [L_DEPTH];
  logic [P_FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [P_FIFO_AW:0] cnt_q, cnt_d;
  logic push, pop, full, wr;
  gci_std_kmc_ps2_filter #(.P_FILTER_CYCLES(P_FILTER_CYCLES)) u_clk_filter (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iIN(iPS2_CLOCK), .oOUT(fclk)
  );
  gci_std_kmc_ps2_filter #(.P_FILTER_CYCLES(P_FILTER_CYCLES)) u_dat_filter (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iIN(iPS2_DATA), .oOUT(fdat)
  );
  assign fall = clk_d1_q & ~fclk;
  assign oRX_VALID = cnt_q != '0;
  assign oRX_DATA = oRX_VALID ? mem_q[rp_q] : 8'h00;
  assign oFIFO_COUNT = cnt_q;
  assign oBUSY = state_q != L_PS2_IDLE;
  assign oERR_FRAME = err_frame_q;
  assign oERR_PARITY = err_parity_q;
  assign oERR_TIMEOUT = err_timeout_q;
  assign oERR_OVERFLOW = err_overflow_q;
  assign pop = oRX_VALID & iRX_READY;
  assign full = cnt_q == (P_FIFO_AW + 1)'(L_DEPTH);
  // frame decode on filtered clock falls, inter-bit timeout, FIFO update; iCLEAR overrides all
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    tmo_d = (state_q == L_PS2_IDLE) ? '0 : tmo_q + 1'b1;
    push = 1'b0;
    err_frame_d = 1'b0;
    err_parity_d = 1'b0;
    err_timeout_d = 1'b0;
    if (fall) begin
      tmo_d = '0;
      case (state_q)
        L_PS2_IDLE: begin
          err_frame_d = fdat;
          state_d = fdat ? L_PS2_IDLE : L_PS2_DATA;
          bit_d = 3'd0;
        end
        L_PS2_DATA: begin
          shift_d = {fdat, shift_q[7:1]};
          bit_d = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? L_PS2_PARITY : L_PS2_DATA;
        end
        L_PS2_PARITY: begin
          par_d = fdat;
          state_d = L_PS2_STOP;
        end
        default: begin
          state_d = L_PS2_IDLE;
          err_frame_d = ~fdat;
          err_parity_d = fdat & ~^{shift_q, par_q};
          push = fdat & ^{shift_q, par_q};
        end
      endcase
    end else if (state_q != L_PS2_IDLE && tmo_q == L_TW'(P_TIMEOUT_CYCLES - 1)) begin
      state_d = L_PS2_IDLE;
      err_timeout_d = 1'b1;
      tmo_d = '0;
    end
    wr = push & (~full | pop);
    err_overflow_d = push & full & ~pop;
    mem_d = mem_q;
    if (wr) mem_d[wp_q] = shift_q;
    wp_d = wp_q + P_FIFO_AW'(wr);
    rp_d = rp_q + P_FIFO_AW'(pop);
    cnt_d = cnt_q + (P_FIFO_AW + 1)'(wr) - (P_FIFO_AW + 1)'(pop);
    if (iCLEAR) begin
      state_d = L_PS2_IDLE;
      tmo_d = '0;
      wp_d = '0;
      rp_d = '0;
      cnt_d = '0;
      err_frame_d = 1'b0;
      err_parity_d = 1'b0;
      err_timeout_d = 1'b0;
      err_overflow_d = 1'b0;
    end
  end
  // state, FIFO and registered error pulses
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      clk_d1_q <= 1'b1;
      state_q <= L_PS2_IDLE;
      bit_q <= 3'd0;
      shift_q <= 8'h00;
      par_q <= 1'b0;
      tmo_q <= '0;
      err_frame_q <= 1'b0;
      err_parity_q <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overflow_q <= 1'b0;
      mem_q <= '{default: 8'h00};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      clk_d1_q <= fclk;
      state_q <= state_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      tmo_q <= tmo_d;
      err_frame_q <= err_frame_d;
      err_parity_q <= err_parity_d;
      err_timeout_q <= err_timeout_d;
      err_overflow_q <= err_overflow_d;
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_gci_std_kmc_ps2_rx_frame.sv
// tb_gci_std_kmc_ps2_rx_frame: table, directed and random frames against a frame-level model
module tb_gci_std_kmc_ps2_rx_frame;
  logic iCLOCK = 0, inRESET = 0, iCLEAR = 0, iPS2_CLOCK = 1, iPS2_DATA = 1, iRX_READY = 1;
  logic oRX_VALID, oBUSY, oERR_FRAME, oERR_PARITY, oERR_TIMEOUT, oERR_OVERFLOW;
  logic [7:0] oRX_DATA;
  logic [2:0] oFIFO_COUNT;
  int checks = 0, failures = 0;
  int n_fr = 0, n_pa = 0, n_to = 0, n_ov = 0;
  logic [7:0] got[$];
  typedef struct {logic [7:0] d; logic par; logic stop; int e_fr; int e_pa; int e_push;} vec_t;
  vec_t tbl[8];
  gci_std_kmc_ps2_rx_frame #(.P_FILTER_CYCLES(4), .P_TIMEOUT_CYCLES(400), .P_FIFO_AW(2)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iCLEAR(iCLEAR), .iPS2_CLOCK(iPS2_CLOCK),
    .iPS2_DATA(iPS2_DATA), .oRX_VALID(oRX_VALID), .oRX_DATA(oRX_DATA), .iRX_READY(iRX_READY),
    .oFIFO_COUNT(oFIFO_COUNT), .oBUSY(oBUSY), .oERR_FRAME(oERR_FRAME), .oERR_PARITY(oERR_PARITY),
    .oERR_TIMEOUT(oERR_TIMEOUT), .oERR_OVERFLOW(oERR_OVERFLOW)
  );
  always #5 iCLOCK = ~iCLOCK;
  // count pulse cycles and record popped bytes away from the active edge
  always @(negedge iCLOCK) if (inRESET) begin
    if (oERR_FRAME) n_fr++;
    if (oERR_PARITY) n_pa++;
    if (oERR_TIMEOUT) n_to++;
    if (oERR_OVERFLOW) n_ov++;
    if (oRX_VALID && iRX_READY) got.push_back(oRX_DATA);
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge iCLOCK);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction
  task automatic clr_counts();
    n_fr = 0; n_pa = 0; n_to = 0; n_ov = 0;
    got.delete();
  endtask
  task automatic send_bits(input logic [10:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      iPS2_DATA = v[i];
      wait_cyc(20);
      iPS2_CLOCK = 0;
      wait_cyc(40);
      iPS2_CLOCK = 1;
      wait_cyc(20);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bits({stop, par, d, 1'b0}, 11);
    iPS2_DATA = 1;
    wait_cyc(60);
  endtask
  task automatic run_frame(input string tag, input logic [7:0] d, input logic par, input logic stop,
                           input int e_fr, input int e_pa, input int e_push);
    clr_counts();
    send_frame(d, par, stop);
    chk({tag, "_frame_err"}, n_fr, e_fr);
    chk({tag, "_parity_err"}, n_pa, e_pa);
    chk({tag, "_timeout_err"}, n_to, 0);
    chk({tag, "_pushes"}, got.size(), e_push);
    if (e_push != 0 && got.size() != 0) chk({tag, "_data"}, got[0], d);
  endtask
  initial begin
    tbl[0] = '{8'h1C, 1'b0, 1'b1, 0, 0, 1};
    tbl[1] = '{8'hF0, 1'b0, 1'b1, 0, 1, 0};
    tbl[2] = '{8'h5A, 1'b1, 1'b0, 1, 0, 0};
    tbl[3] = '{8'h12, 1'b1, 1'b1, 0, 0, 1};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 0, 0, 1};
    tbl[5] = '{8'h00, 1'b1, 1'b1, 0, 0, 1};
    tbl[6] = '{8'hF0, 1'b0, 1'b0, 1, 0, 0};
    tbl[7] = '{8'h80, 1'b0, 1'b1, 0, 0, 1};
    wait_cyc(5);
    chk("rst_valid", oRX_VALID, 0);
    chk("rst_data", oRX_DATA, 8'h00);
    chk("rst_count", oFIFO_COUNT, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_errs", {oERR_FRAME, oERR_PARITY, oERR_TIMEOUT, oERR_OVERFLOW}, 0);
    inRESET = 1;
    wait_cyc(20);
    for (int i = 0; i < 8; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i].d, tbl[i].par, tbl[i].stop, tbl[i].e_fr, tbl[i].e_pa, tbl[i].e_push);
    clr_counts();
    send_bits(11'h001, 1);
    iPS2_DATA = 1;
    wait_cyc(20);
    chk("idle_high_start_frame_err", n_fr, 1);
    chk("idle_high_start_busy", oBUSY, 0);
    clr_counts();
    send_bits({2'b11, 8'h55, 1'b0}, 4);
    chk("tmo_busy_mid", oBUSY, 1);
    iPS2_DATA = 1;
    wait_cyc(500);
    chk("tmo_pulse", n_to, 1);
    chk("tmo_busy_after", oBUSY, 0);
    chk("tmo_no_push", got.size(), 0);
    run_frame("after_tmo", 8'h29, odd_par(8'h29), 1'b1, 0, 0, 1);
    clr_counts();
    iRX_READY = 0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), odd_par(8'(i)), 1'b1);
      if (i == 4) chk("ovf_none_at_4", n_ov, 0);
    end
    chk("ovf_count", oFIFO_COUNT, 4);
    chk("ovf_pulse", n_ov, 1);
    chk("ovf_head", oRX_DATA, 8'h01);
    iRX_READY = 1;
    wait_cyc(10);
    chk("drain_n", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("drain%0d", i), got[i], 8'(i + 1));
    chk("drain_empty", oFIFO_COUNT, 0);
    chk("drain_data0", oRX_DATA, 8'h00);
    clr_counts();
    iRX_READY = 0;
    send_frame(8'h44, odd_par(8'h44), 1'b1);
    send_frame(8'h45, odd_par(8'h45), 1'b1);
    chk("clr_pre_count", oFIFO_COUNT, 2);
    send_bits({2'b11, 8'h3C, 1'b0}, 3);
    iCLEAR = 1;
    wait_cyc(1);
    iCLEAR = 0;
    iPS2_DATA = 1;
    chk("clr_count", oFIFO_COUNT, 0);
    chk("clr_valid", oRX_VALID, 0);
    chk("clr_busy", oBUSY, 0);
    wait_cyc(500);
    chk("clr_no_errs", n_fr + n_pa + n_to + n_ov, 0);
    iRX_READY = 1;
    run_frame("after_clr", 8'h3C, odd_par(8'h3C), 1'b1, 0, 0, 1);
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      iPS2_CLOCK = 0;
      wait_cyc(2);
      iPS2_CLOCK = 1;
      wait_cyc(10);
    end
    wait_cyc(20);
    chk("glitch_no_fall", n_fr, 0);
    chk("glitch_busy", oBUSY, 0);
    iRX_READY = 0;
    send_frame(8'h33, odd_par(8'h33), 1'b1);
    send_bits({2'b11, 8'h76, 1'b0}, 5);
    inRESET = 0;
    #2;
    chk("mid_rst_busy", oBUSY, 0);
    chk("mid_rst_valid", oRX_VALID, 0);
    chk("mid_rst_count", oFIFO_COUNT, 0);
    chk("mid_rst_data", oRX_DATA, 8'h00);
    iPS2_DATA = 1;
    wait_cyc(3);
    inRESET = 1;
    iRX_READY = 1;
    wait_cyc(20);
    run_frame("after_rst", 8'h76, odd_par(8'h76), 1'b1, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      logic p, s;
      int efr, epa, epush;
      d = 8'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~odd_par(d) : odd_par(d);
      s = ($urandom_range(0, 4) != 0);
      efr = !s ? 1 : 0;
      epa = (s && ^{d, p} == 1'b0) ? 1 : 0;
      epush = (efr == 0 && epa == 0) ? 1 : 0;
      run_frame($sformatf("rnd%0d", i), d, p, s, efr, epa, epush);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
